// File: rtl/midi_msg_decoder.sv
// MIDI channel-message decoder: tracks running status, forwards data bytes
// with a 2-cycle byteready window and classifies them (first data byte,
// velocity/second data byte, SysEx payload). A 1-deep skid register holds
// a byte that arrives while a window is still open.
module midi_msg_decoder #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       byteready,
  output logic [7:0] databyte,
  output logic       is_data_byte,
  output logic       is_velocity,
  output logic       is_st_note_on,
  output logic       is_st_note_off,
  output logic       is_st_ctrl,
  output logic       is_st_sysex,
  output logic       msg_done
);

  typedef enum logic [1:0] {StIdle, StData1, StData2, StSysex} state_e;

  state_e      state_q, state_d;
  logic [7:0]  run_status_q, run_status_d;
  logic [1:0]  br_cnt_q, br_cnt_d;
  logic        skid_valid_q, skid_valid_d;
  logic [7:0]  skid_byte_q, skid_byte_d;
  logic [7:0]  databyte_q;
  logic        is_data_q, is_vel_q, msg_done_q;

  logic        busy;
  logic        rx_take;
  logic        proc_valid;
  logic [7:0]  proc_byte;
  logic        ch_ok;
  logic        two_byte_msg;
  logic        fwd, fwd_is_data, fwd_is_vel, fwd_done;

  assign busy    = (br_cnt_q != 2'd0);
  // Real-time bytes never enter the pipeline, not even the skid register.
  assign rx_take = rx_valid && (rx_byte[7:3] != 5'b11111);

  // Select which byte is decoded this cycle and manage the skid register.
  always_comb begin
    proc_valid   = 1'b0;
    proc_byte    = rx_byte;
    skid_valid_d = skid_valid_q;
    skid_byte_d  = skid_byte_q;
    if (!busy) begin
      if (skid_valid_q) begin
        // Held byte goes first; a byte arriving now takes its place.
        proc_valid   = 1'b1;
        proc_byte    = skid_byte_q;
        skid_valid_d = rx_take;
        if (rx_take) skid_byte_d = rx_byte;
      end else if (rx_take) begin
        proc_valid = 1'b1;
      end
    end else if (rx_take && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_byte_d  = rx_byte;
    end
  end

  assign ch_ok        = OMNI || (proc_byte[3:0] == CHANNEL);
  // Cx (program change) and Dx (channel pressure) carry a single data byte.
  assign two_byte_msg = (run_status_q[7:5] != 3'b110);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (proc_valid) begin
      if (proc_byte[7]) begin
        if (proc_byte[7:4] != 4'hF) state_d = ch_ok ? StData1 : StIdle;
        else if (proc_byte == 8'hF0) state_d = StSysex;
        else                         state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle:  state_d = StIdle;
          StData1: state_d = two_byte_msg ? StData2 : StData1;
          StData2: state_d = StData1;
          StSysex: state_d = StSysex;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Output decode: running-status update and forwarding decisions.
  always_comb begin
    run_status_d = run_status_q;
    fwd          = 1'b0;
    fwd_is_data  = 1'b0;
    fwd_is_vel   = 1'b0;
    fwd_done     = 1'b0;
    if (proc_valid) begin
      if (proc_byte[7]) begin
        run_status_d = ((proc_byte[7:4] != 4'hF) && ch_ok) ? proc_byte : 8'h00;
      end else begin
        unique case (state_q)
          StIdle: ;
          StData1: begin
            fwd         = 1'b1;
            fwd_is_data = 1'b1;
            fwd_done    = !two_byte_msg;
          end
          StData2: begin
            fwd        = 1'b1;
            fwd_is_vel = 1'b1;
            fwd_done   = 1'b1;
          end
          StSysex: fwd = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A forward opens a 2-cycle window; otherwise the window counts down.
  always_comb begin
    br_cnt_d = busy ? br_cnt_q - 2'd1 : 2'd0;
    if (fwd) br_cnt_d = 2'd2;
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) begin
      run_status_q <= 8'h00;
      br_cnt_q     <= 2'd0;
      skid_valid_q <= 1'b0;
      skid_byte_q  <= 8'h00;
      databyte_q   <= 8'h00;
      is_data_q    <= 1'b0;
      is_vel_q     <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      run_status_q <= run_status_d;
      br_cnt_q     <= br_cnt_d;
      skid_valid_q <= skid_valid_d;
      skid_byte_q  <= skid_byte_d;
      msg_done_q   <= fwd_done;
      if (fwd) begin
        databyte_q <= proc_byte;
        is_data_q  <= fwd_is_data;
        is_vel_q   <= fwd_is_vel;
      end
    end
  end

  logic in_msg;
  assign in_msg = (state_q == StData1) || (state_q == StData2);

  assign byteready      = busy;
  assign databyte       = databyte_q;
  assign is_data_byte   = is_data_q;
  assign is_velocity    = is_vel_q;
  assign msg_done       = msg_done_q;
  assign is_st_note_on  = in_msg && (run_status_q[7:4] == 4'h9);
  assign is_st_note_off = in_msg && (run_status_q[7:4] == 4'h8);
  assign is_st_ctrl     = in_msg && (run_status_q[7:4] == 4'hB);
  assign is_st_sysex    = (state_q == StSysex);

endmodule

// File: doc/midi_msg_decoder.md
MIDI_MSG_DECODER -- requirements
Module: midi_msg_decoder

Interface
REQ-001 SHALL have parameter OMNI, default 1, meaning accept voice messages on every channel when 1.
REQ-002 SHALL have parameter CHANNEL, default 0, meaning the 4-bit channel accepted when OMNI=0.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reg, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: 1-cycle strobe marking a received MIDI byte.
REQ-006 SHALL have port rx_byte, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-007 SHALL have port byteready, output, 1 bit: high for exactly 2 cycles per forwarded byte; all flags and databyte are stable at its falling edge.
REQ-008 SHALL have port databyte, output, 8 bits: the last forwarded byte.
REQ-009 SHALL have port is_data_byte, output, 1 bit: the forwarded byte is the first data byte of a message.
REQ-010 SHALL have port is_velocity, output, 1 bit: the forwarded byte is the second data byte of a message.
REQ-011 SHALL have ports is_st_note_on, is_st_note_off and is_st_ctrl, outputs, 1 bit each: the running status is 9n, 8n or Bn respectively.
REQ-012 SHALL have port is_st_sysex, output, 1 bit: the decoder is inside a SysEx message (F0 seen, F7 not yet seen).
REQ-013 SHALL have port msg_done, output, 1 bit: 1-cycle pulse when a complete channel message has been forwarded.

Function
REQ-014 SHALL implement states IDLE (no valid running status), DATA1, DATA2 and SYSEX.
REQ-015 A status byte 80-EF on an accepted channel SHALL latch the running status, go to DATA1 and produce no byteready.
REQ-016 A status byte 80-EF on a rejected channel (OMNI=0 and low nibble != CHANNEL) SHALL go to IDLE with the running status cleared.
REQ-017 In DATA1, a data byte (bit7=0) SHALL be forwarded with is_data_byte=1 and is_velocity=0.
REQ-018 From DATA1, the next state SHALL be DATA2 for statuses 8x, 9x, Ax, Bx and Ex; for statuses Cx and Dx, msg_done SHALL pulse and the next state SHALL be DATA1.
REQ-019 In DATA2, a data byte SHALL be forwarded with is_velocity=1 and is_data_byte=0; msg_done SHALL pulse and the next state SHALL be DATA1 (running status).
REQ-020 F0 SHALL enter SYSEX, clear the running status and set is_st_sysex.
REQ-021 In SYSEX, data bytes SHALL be forwarded with is_data_byte=0 and is_velocity=0.
REQ-022 F7 SHALL clear is_st_sysex, return to IDLE and produce no byteready.
REQ-023 F1-F6 SHALL clear the running status and go to IDLE.
REQ-024 Real-time bytes F8-FF SHALL be ignored completely: no state change, no byteready, running status kept, including mid-message and inside SysEx.
REQ-025 Data bytes received in IDLE SHALL be discarded.
REQ-026 A status byte arriving in DATA2 SHALL abandon the partial message with no msg_done and be processed as a new status.
REQ-027 Latency SHALL be byteready rising 1 cycle after rx_valid; outputs SHALL update in that same cycle.
REQ-028 If rx_valid is asserted while byteready is high, the byte SHALL be held in a 1-deep skid register and forwarded immediately after the current byteready window ends.
REQ-029 A third byte arriving while the skid register is full SHALL be dropped.
REQ-030 The status flags SHALL reflect the running status while it is valid and SHALL all be 0 in IDLE and SYSEX.

Reset
REQ-031 On reset_reg=1, the state SHALL become IDLE and the running status and skid register SHALL be cleared.
REQ-032 On reset_reg=1, byteready, all is_* flags and msg_done SHALL be 0, and databyte SHALL be 8'h00.
REQ-033 A reset asserted mid-message SHALL discard the partial message; the first data byte after reset SHALL be ignored until a status byte arrives.

Verification
REQ-034 Send 90 3C 64 -> two byteready windows: databyte=3C with is_data_byte=1, then databyte=64 with is_velocity=1; is_st_note_on=1 throughout; one msg_done.
REQ-035 Send 90 3C 64 then 40 00 (running status) -> a second note-on pair is forwarded with databyte=40 then 00.
REQ-036 Send 90 3C, then F8, then 64 -> the F8 is invisible and the velocity byte 64 is forwarded normally.
REQ-037 Send B0 7B 00 with OMNI=0 and CHANNEL=1 -> nothing is forwarded; send B1 7B 00 -> is_st_ctrl=1 and databyte=7B with is_data_byte=1.
REQ-038 Send F0 43 10 F7 then 3C -> 43 and 10 are forwarded with is_st_sysex=1; 3C is discarded.
REQ-039 Issue back-to-back rx_valid on consecutive cycles, then assert reset mid-message -> the skid register delivers the second byte; after reset all outputs are 0 and data bytes are ignored.
